// File: rtl/aes_seed_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// aes_seed_scheduler: expands RO/RW commands into per-chunk AES seeds and arbitrates core issue slots.
// Optional RW anti-starvation is enabled by defining AES_SCHED_STARVE_EN.
module aes_seed_scheduler #(
  parameter int IVWidth         = 64,
  parameter int BIDWidth        = 32,
  parameter int CIDWidth        = 6,
  parameter int AESWidth        = 128,
  parameter int ROHdrChunks     = 2,
  parameter int RWBktChunks     = 20,
  parameter int ROIWaitSteps    = 3,
  parameter int ROCredits       = 64,
  parameter int RWCredits       = 64,
  parameter int RWChunksPerWord = 4,
  parameter int StarveLimit     = 16
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic [IVWidth-1:0]  ROIV,
  input  logic [BIDWidth-1:0] ROBID,
  input  logic                ROIsHeader,
  input  logic                ROValid,
  output logic                ROReady,
  input  logic [IVWidth-1:0]  RWIV,
  input  logic [BIDWidth-1:0] RWBID,
  input  logic                RWValid,
  output logic                RWReady,
  output logic [AESWidth-1:0] CoreSeed,
  output logic [1:0]          CoreTag,
  output logic                CoreValid,
  input  logic                ROCreditRet,
  input  logic                RWCreditRet,
  output logic                CreditErr
);

  localparam int ROCW = $clog2(ROCredits + 1);
  localparam int RWCW = $clog2(RWCredits + 1);
  localparam int ROSW = $clog2(ROCredits + 2);
  localparam int RWSW = $clog2(RWCredits + RWChunksPerWord + 1);

  localparam logic [1:0] TagRoData = 2'b00;
  localparam logic [1:0] TagRoHdr  = 2'b01;
  localparam logic [1:0] TagRw     = 2'b10;
  localparam logic [1:0] TagRoPad  = 2'b11;

  typedef enum logic [1:0] {RoIdle, RoHdr, RoPad, RoData} ro_state_e;

  ro_state_e             ro_state_q, ro_state_d, ro_cur;
  logic [CIDWidth-1:0]   ro_cid_q, ro_cid_d, rw_cid_q, rw_cid_d;
  logic [ROCW-1:0]       ro_cred_q, ro_cred_d;
  logic [RWCW-1:0]       rw_cred_q, rw_cred_d;
  logic [ROSW-1:0]       ro_sum;
  logic [RWSW-1:0]       rw_sum;
  logic                  ro_ovf, rw_ovf;
  logic                  ro_elig, rw_elig, ro_gnt, rw_gnt, ro_last, rw_last, force_rw;
  logic [AESWidth-1:0]   seed_q, seed_d;
  logic [1:0]            tag_q, tag_d;
  logic                  valid_q, cerr_q;

  // In IDLE the incoming command's first phase is issued directly, so commands chain without a bubble.
  always_comb begin
    ro_cur = ro_state_q;
    if (ro_state_q == RoIdle) begin
      if (ROIsHeader)            ro_cur = RoHdr;
      else if (ROIWaitSteps > 0) ro_cur = RoPad;
      else                       ro_cur = RoData;
    end
  end

  assign ro_elig = ROValid && (ro_cred_q != '0);
  assign rw_elig = RWValid && (rw_cred_q != '0);
  assign ro_gnt  = ro_elig && !force_rw;
  assign rw_gnt  = rw_elig && !ro_gnt;

`ifdef AES_SCHED_STARVE_EN
  localparam int SCW = $clog2(StarveLimit + 1);
  logic [SCW-1:0] starve_q;

  assign force_rw = rw_elig && (starve_q >= SCW'(StarveLimit));

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      starve_q <= '0;
    end else if (!RWValid || rw_gnt) begin
      starve_q <= '0;
    end else if (ro_gnt && (starve_q < SCW'(StarveLimit))) begin
      starve_q <= starve_q + SCW'(1);
    end
  end
`else
  assign force_rw = 1'b0;
`endif

  always_comb begin
    ro_state_d = ro_state_q;
    ro_cid_d   = ro_cid_q;
    ro_last    = 1'b0;
    if (ro_gnt) begin
      ro_state_d = ro_cur;
      ro_cid_d   = ro_cid_q + CIDWidth'(1);
      unique case (ro_cur)
        RoHdr: if (ro_cid_q == CIDWidth'(ROHdrChunks - 1)) begin
          ro_last = 1'b1; ro_state_d = RoIdle; ro_cid_d = '0;
        end
        RoPad: if (ro_cid_q == CIDWidth'(ROIWaitSteps - 1)) begin
          ro_state_d = RoData; ro_cid_d = '0;
        end
        RoData: if (ro_cid_q == CIDWidth'(RWBktChunks - 1)) begin
          ro_last = 1'b1; ro_state_d = RoIdle; ro_cid_d = '0;
        end
        default: ro_state_d = RoIdle;
      endcase
    end
  end

  assign rw_last  = (rw_cid_q == CIDWidth'(RWBktChunks - 1));
  assign rw_cid_d = !rw_gnt ? rw_cid_q : (rw_last ? '0 : rw_cid_q + CIDWidth'(1));
  assign ROReady  = ro_gnt && ro_last;
  assign RWReady  = rw_gnt && rw_last;

  always_comb begin
    seed_d = seed_q;
    tag_d  = tag_q;
    if (ro_gnt) begin
      seed_d = AESWidth'({ROIV, ROBID, ro_cid_q});
      unique case (ro_cur)
        RoHdr:   tag_d = TagRoHdr;
        RoPad:   tag_d = TagRoPad;
        default: tag_d = TagRoData;
      endcase
    end else if (rw_gnt) begin
      seed_d = AESWidth'({RWIV, RWBID, rw_cid_q});
      tag_d  = TagRw;
    end
  end

  // Grant and return net together; only the net result is checked against the buffer depth.
  always_comb begin
    ro_sum    = ROSW'(ro_cred_q) + ROSW'(ROCreditRet) - ROSW'(ro_gnt);
    rw_sum    = RWSW'(rw_cred_q) + (RWCreditRet ? RWSW'(RWChunksPerWord) : '0) - RWSW'(rw_gnt);
    ro_ovf    = (ro_sum > ROSW'(ROCredits));
    rw_ovf    = (rw_sum > RWSW'(RWCredits));
    ro_cred_d = ro_ovf ? ROCW'(ROCredits) : ROCW'(ro_sum);
    rw_cred_d = rw_ovf ? RWCW'(RWCredits) : RWCW'(rw_sum);
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      ro_state_q <= RoIdle;
      ro_cid_q   <= '0;
      rw_cid_q   <= '0;
      ro_cred_q  <= ROCW'(ROCredits);
      rw_cred_q  <= RWCW'(RWCredits);
      seed_q     <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      ro_state_q <= ro_state_d;
      ro_cid_q   <= ro_cid_d;
      rw_cid_q   <= rw_cid_d;
      ro_cred_q  <= ro_cred_d;
      rw_cred_q  <= rw_cred_d;
      seed_q     <= seed_d;
      tag_q      <= tag_d;
      valid_q    <= ro_gnt || rw_gnt;
      cerr_q     <= cerr_q || ro_ovf || rw_ovf;
    end
  end

  assign CoreSeed  = seed_q;
  assign CoreTag   = tag_q;
  assign CoreValid = valid_q;
  assign CreditErr = cerr_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_seed_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// tb_aes_seed_scheduler: directed self-checking bench for aes_seed_scheduler.
module tb_aes_seed_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [63:0]  ro_iv, rw_iv, ro_iv4, rw_iv4;
  logic [31:0]  ro_bid, rw_bid, ro_bid4, rw_bid4;
  logic         ro_hdr, ro_valid, rw_valid, ro_cret, rw_cret;
  logic         ro_hdr4, ro_valid4, rw_valid4, ro_cret4, rw_cret4;
  logic         ro_ready, rw_ready, cvalid, cerr;
  logic         ro_ready4, rw_ready4, cvalid4, cerr4;
  logic [127:0] seed, seed4;
  logic [1:0]   tag, tag4;

  aes_seed_scheduler u_dut (
    .Clock(clk), .ResetN(rst_n),
    .ROIV(ro_iv), .ROBID(ro_bid), .ROIsHeader(ro_hdr), .ROValid(ro_valid), .ROReady(ro_ready),
    .RWIV(rw_iv), .RWBID(rw_bid), .RWValid(rw_valid), .RWReady(rw_ready),
    .CoreSeed(seed), .CoreTag(tag), .CoreValid(cvalid),
    .ROCreditRet(ro_cret), .RWCreditRet(rw_cret), .CreditErr(cerr)
  );

  aes_seed_scheduler #(.ROCredits(4)) u_dut4 (
    .Clock(clk), .ResetN(rst_n),
    .ROIV(ro_iv4), .ROBID(ro_bid4), .ROIsHeader(ro_hdr4), .ROValid(ro_valid4), .ROReady(ro_ready4),
    .RWIV(rw_iv4), .RWBID(rw_bid4), .RWValid(rw_valid4), .RWReady(rw_ready4),
    .CoreSeed(seed4), .CoreTag(tag4), .CoreValid(cvalid4),
    .ROCreditRet(ro_cret4), .RWCreditRet(rw_cret4), .CreditErr(cerr4)
  );

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           ro_rdy_n = 0;
  int           rw_rdy_n = 0;
  logic [129:0] q[$];
  int           qc[$];
  logic [129:0] q4[$];

  task automatic chk(input string name, input logic [129:0] obs, input logic [129:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [129:0] ent(input logic [1:0] t, input logic [63:0] iv,
                                       input logic [31:0] bid, input int cid);
    logic [5:0] c;
    c = cid[5:0];
    return {t, 26'b0, iv, bid, c};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cvalid) begin
      q.push_back({tag, seed});
      qc.push_back(cyc);
    end
    if (cvalid4) q4.push_back({tag4, seed4});
    if (ro_ready) ro_rdy_n++;
    if (rw_ready) rw_rdy_n++;
  end

  task automatic clear_log();
    q.delete(); qc.delete(); q4.delete();
    ro_rdy_n = 0; rw_rdy_n = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {ro_valid, rw_valid, ro_hdr, ro_cret, rw_cret} = '0;
    {ro_valid4, rw_valid4, ro_hdr4, ro_cret4, rw_cret4} = '0;
    ro_iv = '0; rw_iv = '0; ro_bid = '0; rw_bid = '0;
    ro_iv4 = '0; rw_iv4 = '0; ro_bid4 = '0; rw_bid4 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
  endtask

  task automatic wait_ro(input int bound);
    logic seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (ro_ready) seen = 1'b1;
    end
    @(posedge clk); #1 ro_valid = 1'b0;
    chk("ro_ready_seen", seen, 1);
  endtask

  task automatic wait_rw(input int bound);
    logic seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (rw_ready) seen = 1'b1;
    end
    @(posedge clk); #1 rw_valid = 1'b0;
    chk("rw_ready_seen", seen, 1);
  endtask

  initial begin
    int n;
    logic [129:0] e;

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", cvalid, 0);
    chk("rst_seed", seed, 0);
    chk("rst_tag", tag, 0);
    chk("rst_cerr", cerr, 0);
    chk("rst_ready", {ro_ready, rw_ready}, 0);

    // 1: RO header, two back-to-back seeds
    do_reset();
    ro_iv = 64'h0123_4567_89AB_CDEF; ro_bid = 32'd5; ro_hdr = 1'b1; ro_valid = 1'b1;
    wait_ro(10);
    repeat (3) @(posedge clk); #1;
    chk("t1_count", q.size(), 2);
    chk("t1_cid0", q[0], ent(2'b01, 64'h0123_4567_89AB_CDEF, 32'd5, 0));
    chk("t1_cid1", q[1], ent(2'b01, 64'h0123_4567_89AB_CDEF, 32'd5, 1));
    chk("t1_b2b", qc[1] - qc[0], 1);
    chk("t1_ready", ro_rdy_n, 1);

    // 2: RO data with 3 pad chunks
    do_reset();
    ro_iv = 64'hFEDC_BA98_7654_3210; ro_bid = 32'd9; ro_hdr = 1'b0; ro_valid = 1'b1;
    wait_ro(40);
    repeat (3) @(posedge clk); #1;
    chk("t2_count", q.size(), 23);
    for (int i = 0; i < 23; i++) begin
      e = (i < 3) ? ent(2'b11, 64'hFEDC_BA98_7654_3210, 32'd9, i)
                  : ent(2'b00, 64'hFEDC_BA98_7654_3210, 32'd9, i - 3);
      chk($sformatf("t2_seed%0d", i), q[i], e);
    end
    chk("t2_contig", qc[22] - qc[0], 22);
    chk("t2_ready", ro_rdy_n, 1);

    // 3: RO header preempts RW bucket at CID 7
    do_reset();
    rw_iv = 64'h1111_2222_3333_4444; rw_bid = 32'h77; rw_valid = 1'b1;
    repeat (7) @(posedge clk); #1;
    ro_iv = 64'hAAAA_BBBB_CCCC_DDDD; ro_bid = 32'd3; ro_hdr = 1'b1; ro_valid = 1'b1;
    wait_ro(10);
    wait_rw(40);
    repeat (3) @(posedge clk); #1;
    chk("t3_count", q.size(), 22);
    for (int i = 0; i < 22; i++) begin
      if (i < 7)       e = ent(2'b10, 64'h1111_2222_3333_4444, 32'h77, i);
      else if (i < 9)  e = ent(2'b01, 64'hAAAA_BBBB_CCCC_DDDD, 32'd3, i - 7);
      else             e = ent(2'b10, 64'h1111_2222_3333_4444, 32'h77, i - 2);
      chk($sformatf("t3_seed%0d", i), q[i], e);
    end
    chk("t3_ready", {ro_rdy_n[7:0], rw_rdy_n[7:0]}, {8'd1, 8'd1});

    // 4: RO blocked on credits (depth 4) lets RW through; one return admits one more RO chunk
    do_reset();
    ro_iv4 = 64'h4444_0000_0000_0004; ro_bid4 = 32'd12; ro_hdr4 = 1'b0; ro_valid4 = 1'b1;
    rw_iv4 = 64'h5555_0000_0000_0005; rw_bid4 = 32'd34; rw_valid4 = 1'b1;
    repeat (10) @(posedge clk); #1 ro_cret4 = 1'b1;
    @(posedge clk); #1 ro_cret4 = 1'b0;
    repeat (6) @(posedge clk); #1;
    ro_valid4 = 1'b0; rw_valid4 = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t4_count", q4.size(), 17);
    n = 0;
    for (int i = 0; i < 10; i++) if (q4[i][129:128] != 2'b10) n++;
    chk("t4_ro_first10", n, 4);
    chk("t4_last_ro", q4[3], ent(2'b00, 64'h4444_0000_0000_0004, 32'd12, 0));
    chk("t4_rw_first", q4[4], ent(2'b10, 64'h5555_0000_0000_0005, 32'd34, 0));
    chk("t4_rw_ret", q4[10], ent(2'b10, 64'h5555_0000_0000_0005, 32'd34, 6));
    chk("t4_ro_extra", q4[11], ent(2'b00, 64'h4444_0000_0000_0004, 32'd12, 1));
    chk("t4_rw_resume", q4[12], ent(2'b10, 64'h5555_0000_0000_0005, 32'd34, 7));
    n = 0;
    for (int i = 0; i < q4.size(); i++) if (q4[i][129:128] != 2'b10) n++;
    chk("t4_ro_total", n, 5);

    // 5: continuous RO with RW pending
    do_reset();
    ro_iv = 64'h0000_0000_0000_00A1; ro_bid = 32'd1; ro_hdr = 1'b0; ro_valid = 1'b1;
    rw_iv = 64'h0000_0000_0000_00B2; rw_bid = 32'd2; rw_valid = 1'b1;
    repeat (51) @(posedge clk); #1;
    ro_valid = 1'b0; rw_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t5_count", q.size(), 51);
    n = 0;
    for (int i = 0; i < 51; i++) if (q[i][129:128] == 2'b10) n++;
`ifdef AES_SCHED_STARVE_EN
    chk("t5_rw_grants", n, 3);
    chk("t5_slot16", q[16], ent(2'b10, 64'h0000_0000_0000_00B2, 32'd2, 0));
    chk("t5_slot17", q[17], ent(2'b00, 64'h0000_0000_0000_00A1, 32'd1, 13));
    chk("t5_slot50", q[50], ent(2'b10, 64'h0000_0000_0000_00B2, 32'd2, 2));
`else
    chk("t5_rw_grants", n, 0);
    chk("t5_slot16", q[16], ent(2'b00, 64'h0000_0000_0000_00A1, 32'd1, 13));
    chk("t5_slot17", q[17], ent(2'b00, 64'h0000_0000_0000_00A1, 32'd1, 14));
`endif
    chk("t5_ro_ready", ro_rdy_n, 2);

    // 6: return at full credits, then async reset mid-bucket
    do_reset();
    rw_cret = 1'b1;
    @(posedge clk); #1 rw_cret = 1'b0;
    chk("t6_cerr_set", cerr, 1);
    rw_iv = 64'hCAFE_F00D_0000_0006; rw_bid = 32'd66; rw_valid = 1'b1;
    repeat (70) @(posedge clk); #1;
    chk("t6_rw_grants", q.size(), 64);
    chk("t6_rw_ready", rw_rdy_n, 3);
    chk("t6_last", q[63], ent(2'b10, 64'hCAFE_F00D_0000_0006, 32'd66, 3));
    chk("t6_cerr_sticky", cerr, 1);
    rw_cret = 1'b1;
    @(posedge clk); #1 rw_cret = 1'b0;
    @(posedge clk); #1;
    chk("t6_pre_rst", {tag, seed}, ent(2'b10, 64'hCAFE_F00D_0000_0006, 32'd66, 4));
    chk("t6_pre_valid", cvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", cvalid, 0);
    chk("t6_rst_seed", {tag, seed}, 0);
    chk("t6_rst_cerr", cerr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_log();
    repeat (70) @(posedge clk); #1;
    rw_valid = 1'b0;
    chk("t6_post_first", q[0], ent(2'b10, 64'hCAFE_F00D_0000_0006, 32'd66, 0));
    chk("t6_post_grants", q.size(), 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
